serial_receiver: RTL and testbench
==================================

// Module: serial_receiver
// PURPOSE
//  UART-style serial receiver: deserialises 8N1 frames from the async line into bytes.
//  Sits directly upstream of serial_transceiver's byte path.
//  Presents each byte on a valid/ready handshake.
//  Flags framing errors and overruns.
//  Default timing matches the line rate used across the codebase: 5208 clk per bit.
// PARAMETERS
//  CLK_DIV    5208  clk cycles per bit period (>= 4)
//  DATA_BITS  8     data bits per frame, LSB first
// PORTS
//  clk        in   1          system clock; single clock domain
//  rst        in   1          synchronous, active-high reset
//  din        in   1          async serial line, idle high
//  dout       out  DATA_BITS  received byte, stable while valid=1
//  valid      out  1          dout holds an unconsumed byte
//  ready      in   1          consumer accepts; transfer when valid&&ready at posedge
//  frame_err  out  1          1-cycle pulse: stop bit sampled 0
//  overrun    out  1          1-cycle pulse: byte completed while valid&&!ready, new byte dropped
//  parity_err out  1          1-cycle pulse (PARITY_EN only; tied 0 otherwise)
// BEHAVIOUR
//  Reset values: dout=0, valid=0, frame_err=0, overrun=0, parity_err=0, state=IDLE.
//  Reset values (cont.): sync flops=1, bit counter=0, cycle counter=0.
//  din passes through a 2-flop synchroniser; all decisions use the synchronised value s_din.
//  States:
//   IDLE  wait for s_din==0; on it, clear cycle counter and go to START.
//   START at count CLK_DIV/2-1 (mid start bit): s_din==0 -> DATA, bit idx=0;
//         s_din==1 -> false start, back to IDLE, no flags.
//   DATA  every CLK_DIV cycles sample s_din into shift reg[idx]; after DATA_BITS samples -> STOP
//         (-> PARITY if PARITY_EN).
//   STOP  sample at mid stop bit:
//         s_din==1 -> commit byte, return to IDLE immediately (re-arms during 2nd half of stop bit);
//         s_din==0 -> frame_err pulse, byte discarded, go to BREAK.
//   BREAK wait for s_din==1, then IDLE (line held low must not produce repeated frames).
//  Commit: if !valid || ready in the same cycle -> dout<=byte, valid<=1 next cycle.
//   Simultaneous consume+commit is legal and valid stays 1 with the new byte.
//  Commit with valid && !ready -> overrun pulse; dout keeps the old byte.
//  Latency: valid rises 1 clk after the mid-stop-bit sample (~2 clk + 9.5 bit periods after the start edge).
//  Cycle counter width $clog2(CLK_DIV); it wraps to 0 at CLK_DIV-1, with no off-by-one drift across the frame.
//  rst mid-frame aborts the frame: no byte, no flags; next frame is received normally.
// CONFIGURATION
//  Macro SERIAL_RX_PARITY_EN:
//   defined -> 8E1 framing; state PARITY between DATA and STOP samples an even-parity bit.
//     On mismatch: parity_err pulses at the stop sample and the byte is discarded, even if the stop bit is good.
//     If the stop bit is 0, frame_err takes precedence.
//   undefined -> 8N1; no PARITY state; parity_err tied 0.
// STRUCTURE
//  Shared header uart_defs.vh: state encodings (IDLE, START, DATA, PARITY, STOP, BREAK) and default CLK_DIV=5208.
//  uart_defs.vh is reused by serial_transceiver and future TX blocks.
//  Sub-module bit_timer: cycle counter with clear input.
//   Outputs mid_tick (count==CLK_DIV/2-1) and bit_tick (count==CLK_DIV-1).
// TESTING (CLK_DIV=5208, 10416 time units per bit with 2-unit clk period)
//  1 Frame 0,1,1,0,0,0,1,1,0,1 (start,data LSB-first,stop) -> dout=8'h63, valid=1, no flags.
//  2 Idle ~400k units, then frame 0,0,1,1,1,0,0,0,1,1 -> dout=8'h8E; hold ready=0 during frames 1-2 -> overrun pulse, dout stays 8'h63.
//  3 Glitch: din low for 1000 units then high -> no valid, no flags, state back to IDLE.
//  4 Frame 8'hA5 with stop bit 0, line held low 3 bit times -> one frame_err pulse, no valid.
//  4 (cont.) After the line returns high, a subsequent 8'h5A frame is received correctly.
//  5 Assert rst mid-DATA of 8'h3C -> valid stays 0; next frame 8'hC3 received -> dout=8'hC3.
//  6 PARITY_EN: 8'h01 with parity bit 0 -> parity_err pulse, no valid; with parity 1 -> dout=8'h01.

Source files
------------

// File: rtl/serial_receiver_pkg.sv
// Shared definitions for the serial receiver: FSM state encoding, default line rate
// and the even-parity helper used when SERIAL_RX_PARITY_EN is defined.
package serial_receiver_pkg;

    localparam int DEFAULT_CLK_DIV = 5208;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } rx_state_t;

    // Even-parity bit: the value that makes the total count of ones even.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/serial_receiver_bit_timer.sv
// Free-running bit-period counter with synchronous clear; flags the middle and the
// last cycle of each bit period.
module serial_receiver_bit_timer
    import serial_receiver_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic mid_tick,
    output logic bit_tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] MID_COUNT  = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(CLK_DIV - 1);

    logic [CW-1:0] count_r;

    // cycle counter, wraps at the end of each bit period
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (clear || (count_r == LAST_COUNT)) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

    assign mid_tick = (count_r == MID_COUNT);
    assign bit_tick = (count_r == LAST_COUNT);

endmodule

// File: rtl/serial_receiver.sv
// UART-style receiver: 8N1 frames from an async line to a valid/ready byte stream.
// Define SERIAL_RX_PARITY_EN for 8E1 framing with a parity check.
module serial_receiver
    import serial_receiver_pkg::*;
#(
    parameter int CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

    rx_state_t            state_r, state_s;
    logic                 sync1_r, sync2_r, s_din;
    logic [IW-1:0]        idx_r, idx_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic                 mid_tick_s, bit_tick_s, clear_s;
    logic                 commit_s, frame_err_s, parity_err_s;
    logic [DATA_BITS-1:0] dout_r;
    logic                 valid_r, frame_err_r, overrun_r, parity_err_r;
`ifdef SERIAL_RX_PARITY_EN
    logic                 par_ok_r, par_ok_s;
`endif

    assign s_din = sync2_r;

    serial_receiver_bit_timer #(.CLK_DIV(CLK_DIV)) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear_s),
        .mid_tick (mid_tick_s),
        .bit_tick (bit_tick_s)
    );

    // Frame sequencing. The timer is realigned at mid start bit so every later
    // sample lands on bit_tick, exactly one bit period apart.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        shift_s      = shift_r;
        clear_s      = 1'b0;
        commit_s     = 1'b0;
        frame_err_s  = 1'b0;
        parity_err_s = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        par_ok_s     = par_ok_r;
`endif
        case (state_r)
            IDLE: begin
                clear_s = 1'b1;
                if (!s_din) state_s = START;
                else        state_s = IDLE;
            end
            START: begin
                if (mid_tick_s) begin
                    clear_s = 1'b1;
                    idx_s   = '0;
                    if (!s_din) state_s = DATA;
                    else        state_s = IDLE;
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bit_tick_s) begin
                    shift_s[idx_r] = s_din;
                    idx_s          = idx_r + IW'(1);
`ifdef SERIAL_RX_PARITY_EN
                    if (idx_r == LAST_IDX) state_s = PARITY;
`else
                    if (idx_r == LAST_IDX) state_s = STOP;
`endif
                    else                   state_s = DATA;
                end else begin
                    state_s = DATA;
                end
            end
`ifdef SERIAL_RX_PARITY_EN
            PARITY: begin
                if (bit_tick_s) begin
                    par_ok_s = (even_parity(32'(shift_r)) == s_din);
                    state_s  = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
`endif
            STOP: begin
                if (bit_tick_s) begin
                    if (s_din) begin
`ifdef SERIAL_RX_PARITY_EN
                        if (par_ok_r) commit_s     = 1'b1;
                        else          parity_err_s = 1'b1;
`else
                        commit_s = 1'b1;
`endif
                        state_s = IDLE;
                    end else begin
                        frame_err_s = 1'b1;
                        state_s     = BREAK;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            BREAK: begin
                if (s_din) state_s = IDLE;
                else       state_s = BREAK;
            end
            default: state_s = IDLE;
        endcase
    end

    // Line synchroniser and frame state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            state_r <= IDLE;
            idx_r   <= '0;
            shift_r <= '0;
`ifdef SERIAL_RX_PARITY_EN
            par_ok_r <= 1'b1;
`endif
        end else begin
            sync1_r <= din;
            sync2_r <= sync1_r;
            state_r <= state_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
`ifdef SERIAL_RX_PARITY_EN
            par_ok_r <= par_ok_s;
`endif
        end
    end

    // Output handshake: a commit into a still-held byte is dropped as an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_r       <= '0;
            valid_r      <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            frame_err_r  <= frame_err_s;
            parity_err_r <= parity_err_s;
            overrun_r    <= commit_s && valid_r && !ready;
            if (commit_s && (!valid_r || ready)) begin
                dout_r  <= shift_r;
                valid_r <= 1'b1;
            end else if (valid_r && ready) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign dout       = dout_r;
    assign valid      = valid_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
    assign parity_err = parity_err_r;

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver at a shortened bit period; parity scenarios
// run only when SERIAL_RX_PARITY_EN is defined.
module tb_serial_receiver;
    import serial_receiver_pkg::*;

    localparam int CD    = 16;
    localparam int BIT_T = 2 * CD;

    logic       clk = 1'b0, rst = 1'b1, din = 1'b1, ready = 1'b0;
    logic [7:0] dout;
    logic       valid, frame_err, overrun, parity_err;

    int errors = 0, checks = 0;
    int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    serial_receiver #(.CLK_DIV(CD), .DATA_BITS(8)) dut (
        .clk(clk), .rst(rst), .din(din), .dout(dout), .valid(valid), .ready(ready),
        .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
    );

    always #1 clk = ~clk;

    // Pulse counters and handshake capture, sampled away from the active edge.
    always @(negedge clk) begin
        if (frame_err === 1'b1)  fe_cnt++;
        if (overrun === 1'b1)    ov_cnt++;
        if (parity_err === 1'b1) pe_cnt++;
        if (valid === 1'b1 && ready === 1'b1 && !rst) got_q.push_back(dout);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Frame bits: start, data LSB first, [parity], stop; optional low hold and mid-frame reset.
    task automatic send_frame(input logic [7:0] data, input logic flip_par, input logic stop,
                              input int rst_from, input int low_after);
        logic [10:0] bits;
        int n;
`ifdef SERIAL_RX_PARITY_EN
        bits = {stop, (^data) ^ flip_par, data, 1'b0};
        n = 11;
`else
        bits = {(^data) ^ flip_par, stop, data, 1'b0};
        n = 10;
`endif
        @(negedge clk);
        for (int i = 0; i < n; i++) begin
            if (rst_from >= 0 && i >= rst_from) rst = 1'b1;
            din = bits[i];
            #(BIT_T);
        end
        if (low_after > 0) begin
            din = 1'b0;
            #(low_after * BIT_T);
        end
        din = 1'b1;
        rst = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && valid !== 1'b1; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; din = 1'b1; ready = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected %h", dout, 8'h00); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
        checks++; if (dut.state_r !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state_r, IDLE); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_frame;
        int f0;
        f0 = fe_cnt;
        ready = 1'b0;
        exp_q.push_back(8'h63);
        send_frame(8'h63, 1'b0, 1'b1, -1, 0);
        wait_valid(4 * CD);
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL frame_valid: got %b expected 1", valid); end
        checks++; if (dout !== 8'h63) begin errors++; $display("FAIL frame_dout: got %h expected %h", dout, 8'h63); end
        checks++; if (fe_cnt !== f0) begin errors++; $display("FAIL frame_no_ferr: got %0d expected %0d", fe_cnt, f0); end
    endtask

    task automatic test_overrun;
        int o0;
        logic [7:0] e, g;
        repeat (10 * CD) @(negedge clk);
        o0 = ov_cnt;
        send_frame(8'h8E, 1'b0, 1'b1, -1, 0);
        repeat (4) @(negedge clk);
        checks++; if (ov_cnt !== o0 + 1) begin errors++; $display("FAIL overrun_pulse: got %0d expected %0d", ov_cnt, o0 + 1); end
        checks++; if (dout !== 8'h63) begin errors++; $display("FAIL overrun_dout_kept: got %h expected %h", dout, 8'h63); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b expected 1", valid); end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        checks++; if (g !== e) begin errors++; $display("FAIL consume_byte: got %h expected %h", g, e); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL consume_valid_low: got %b expected 0", valid); end
    endtask

    task automatic test_glitch;
        int f0;
        f0 = fe_cnt;
        @(negedge clk);
        din = 1'b0;
        #((CD / 2 - 4) * 2);
        din = 1'b1;
        repeat (3 * CD) @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", valid); end
        checks++; if (fe_cnt !== f0) begin errors++; $display("FAIL glitch_flags: got %0d expected %0d", fe_cnt, f0); end
        checks++; if (dut.state_r !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", dut.state_r, IDLE); end
    endtask

    task automatic test_break;
        int f0;
        logic [7:0] e, g;
        f0 = fe_cnt;
        send_frame(8'hA5, 1'b0, 1'b0, -1, 3);
        repeat (2 * CD) @(negedge clk);
        checks++; if (fe_cnt !== f0 + 1) begin errors++; $display("FAIL break_frame_err: got %0d expected %0d", fe_cnt, f0 + 1); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL break_valid: got %b expected 0", valid); end
        ready = 1'b1;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b0, 1'b1, -1, 0);
        repeat (4) @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        checks++; if (g !== e) begin errors++; $display("FAIL after_break_byte: got %h expected %h", g, e); end
    endtask

    task automatic test_reset_midframe;
        int f0, o0, p0;
        logic [7:0] e, g;
        f0 = fe_cnt; o0 = ov_cnt; p0 = pe_cnt;
        ready = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1, 5, 0);
        repeat (2 * CD) @(negedge clk);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rst_abort_bytes: got %0d expected 0", got_q.size()); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rst_abort_valid: got %b expected 0", valid); end
        checks++; if (fe_cnt + ov_cnt + pe_cnt !== f0 + o0 + p0) begin errors++; $display("FAIL rst_abort_flags: got %0d expected %0d", fe_cnt + ov_cnt + pe_cnt, f0 + o0 + p0); end
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b0, 1'b1, -1, 0);
        repeat (4) @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        checks++; if (g !== e) begin errors++; $display("FAIL after_rst_byte: got %h expected %h", g, e); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e, g;
        ready = 1'b1;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b0, 1'b1, -1, 0);
        exp_q.push_back(8'hEE);
        send_frame(8'hEE, 1'b0, 1'b1, -1, 0);
        repeat (4) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
            g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL b2b_byte%0d: got %h expected %h", k, g, e); end
        end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL b2b_extra: got %0d expected 0", got_q.size()); end
    endtask

    task automatic test_parity;
        int p0;
        logic [7:0] e, g;
        p0 = pe_cnt;
        ready = 1'b1;
`ifdef SERIAL_RX_PARITY_EN
        send_frame(8'h01, 1'b1, 1'b1, -1, 0);
        repeat (4) @(negedge clk);
        checks++; if (pe_cnt !== p0 + 1) begin errors++; $display("FAIL parity_err_pulse: got %0d expected %0d", pe_cnt, p0 + 1); end
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL parity_drop: got %0d expected 0", got_q.size()); end
        exp_q.push_back(8'h01);
        send_frame(8'h01, 1'b0, 1'b1, -1, 0);
        repeat (4) @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
        g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        checks++; if (g !== e) begin errors++; $display("FAIL parity_ok_byte: got %h expected %h", g, e); end
`else
        e = 8'h00;
        g = 8'h00;
        checks++; if (pe_cnt !== 0) begin errors++; $display("FAIL parity_tied_low: got %0d expected 0 (%h %h)", pe_cnt, g, e); end
`endif
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overrun();
        test_glitch();
        test_break();
        test_reset_midframe();
        test_back_to_back();
        test_parity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
